// File: rtl/gpu_arb_pkg.sv
// Shared types and constants for the GPU memory arbiters.
package gpu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAITING  = 2'd1,
    RELAYING = 2'd2
  } arb_state_t;

  localparam arb_state_t  STATE_RST = IDLE;
  localparam int unsigned IDX_RST   = 0;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_select
  import gpu_arb_pkg::*;
#(
  parameter  int unsigned N = 2,
  localparam int unsigned W = idx_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  // Upper segment [ptr, N) has priority over the wrapped segment [0, ptr).
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && req[k] && (k >= 32'(ptr))) begin
        found = 1'b1;
        idx   = W'(k);
      end
    end
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && req[k] && (k < 32'(ptr))) begin
        found = 1'b1;
        idx   = W'(k);
      end
    end
  end

endmodule

// File: rtl/program_mem_arbiter.sv
// Round-robin arbiter sharing one program-memory read port among core fetchers.
module program_mem_arbiter
  import gpu_arb_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 16,
  parameter int unsigned NUM_CONSUMERS = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
  input  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
  output logic [DATA_BITS-1:0]     consumer_read_data    [NUM_CONSUMERS],
  output logic                     mem_read_valid,
  output logic [ADDR_BITS-1:0]     mem_read_address,
  input  logic                     mem_read_ready,
  input  logic [DATA_BITS-1:0]     mem_read_data
);

  localparam int unsigned IDX_W = idx_width(NUM_CONSUMERS);

  arb_state_t                 state_q, state_d;
  logic [IDX_W-1:0]           grant_q, grant_d;
  logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic                       mem_valid_q, mem_valid_d;
  logic [ADDR_BITS-1:0]       mem_addr_q, mem_addr_d;
  logic [NUM_CONSUMERS-1:0]   cons_ready_q, cons_ready_d;
  logic [DATA_BITS-1:0]       cons_data_q [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]       cons_data_d [NUM_CONSUMERS];

  logic                       pick_found;
  logic [IDX_W-1:0]           pick_idx;

  rr_select #(
    .N (NUM_CONSUMERS)
  ) u_rr_select (
    .req   (consumer_read_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state and output logic for the single-outstanding transaction FSM.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    cons_ready_d = cons_ready_q;
    cons_data_d  = cons_data_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d     = pick_idx;
          mem_valid_d = 1'b1;
          mem_addr_d  = consumer_read_address[pick_idx];
          state_d     = WAITING;
        end
      end
      WAITING: begin
        if (mem_read_ready) begin
          mem_valid_d           = 1'b0;
          cons_data_d[grant_q]  = mem_read_data;
          cons_ready_d[grant_q] = 1'b1;
          state_d               = RELAYING;
        end
      end
      RELAYING: begin
        if (!consumer_read_valid[grant_q]) begin
          cons_ready_d[grant_q] = 1'b0;
          // Explicit wrap keeps non-power-of-two counts correct.
          if (32'(grant_q) == NUM_CONSUMERS - 1) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = grant_q + IDX_W'(1);
          end
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= STATE_RST;
      grant_q      <= IDX_W'(IDX_RST);
      rr_ptr_q     <= IDX_W'(IDX_RST);
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      cons_ready_q <= '0;
      cons_data_q  <= '{default: '0};
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      cons_ready_q <= cons_ready_d;
      cons_data_q  <= cons_data_d;
    end
  end

  assign mem_read_valid      = mem_valid_q;
  assign mem_read_address    = mem_addr_q;
  assign consumer_read_ready = cons_ready_q;
  assign consumer_read_data  = cons_data_q;

endmodule

// File: tb/tb_program_mem_arbiter.sv
// Scoreboard bench for program_mem_arbiter with three cores and a behavioural memory.
module tb_program_mem_arbiter;

  localparam int NC = 3;

  typedef struct {
    int          core;
    logic [7:0]  addr;
    logic [15:0] data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [2:0]  cv;
  logic [7:0]  ca [NC];
  logic [2:0]  cr;
  logic [15:0] cd [NC];
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;

  program_mem_arbiter #(
    .ADDR_BITS     (8),
    .DATA_BITS     (16),
    .NUM_CONSUMERS (NC)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .consumer_read_valid   (cv),
    .consumer_read_address (ca),
    .consumer_read_ready   (cr),
    .consumer_read_data    (cd),
    .mem_read_valid        (mem_read_valid),
    .mem_read_address      (mem_read_address),
    .mem_read_ready        (mem_read_ready),
    .mem_read_data         (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sbq [$];
  int          grants [$];
  logic [7:0]  aq [NC][$];
  logic [15:0] memtab [256];
  int          m_ptr     = 0;
  int          mem_delay = 0;
  int          pulse_req = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Memory model: answers after mem_delay cycles (negative = random 0..3).
  initial begin
    int cnt;
    int cur_d;
    int pulse_done;
    cnt = 0; cur_d = 0; pulse_done = 0;
    mem_read_ready = 1'b0;
    mem_read_data  = 16'h0;
    forever begin
      @(negedge clk);
      if (mem_read_ready) begin
        mem_read_ready = 1'b0;
        cnt = 0;
      end else if (pulse_req != pulse_done) begin
        pulse_done     = pulse_req;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hDEAD;
      end else if (mem_read_valid && !reset) begin
        if (cnt == 0) cur_d = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
        cnt++;
        if (cnt > cur_d) begin
          mem_read_ready = 1'b1;
          mem_read_data  = memtab[mem_read_address];
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every rising consumer ready.
  initial begin
    logic [2:0] prev;
    exp_t e;
    prev = 3'b000;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("ready_onehot", 32'($countones(cr) <= 1), 32'd1);
        for (int k = 0; k < NC; k++) begin
          if (cr[k] && !prev[k]) begin
            grants.push_back(k);
            if (sbq.size() == 0) begin
              chk("unexpected_ready_core", 32'(k), 32'hFFFF_FFFF);
            end else begin
              e = sbq.pop_front();
              chk("grant_core", 32'(k), 32'(e.core));
              chk("read_data", 32'(cd[k]), 32'(e.data));
            end
          end
        end
      end
      prev = reset ? 3'b000 : cr;
    end
  end

  // Reference model: cores raised together are served in round-robin order from m_ptr.
  task automatic plan(input logic [2:0] mask, input int rounds, input logic use_fixed,
                      input logic [7:0] fa0, input logic [7:0] fa1, input logic [7:0] fa2);
    logic [7:0] a;
    int k;
    int last;
    for (int r = 0; r < rounds; r++) begin
      last = m_ptr;
      for (int i = 0; i < NC; i++) begin
        k = (m_ptr + i) % NC;
        if (mask[k]) begin
          if (use_fixed) a = (k == 0) ? fa0 : ((k == 1) ? fa1 : fa2);
          else           a = 8'($urandom);
          sbq.push_back('{k, a, memtab[a]});
          aq[k].push_back(a);
          last = k;
        end
      end
      m_ptr = (last + 1) % NC;
    end
  endtask

  // Drive a batch: cores in mask request together and re-request 'rounds' times.
  task automatic run_batch(input logic [2:0] mask, input int rounds);
    int  left [NC];
    int  hold [NC];
    bit  done;
    plan(mask, rounds, 1'b0, 8'h0, 8'h0, 8'h0);
    @(negedge clk);
    for (int k = 0; k < NC; k++) begin
      hold[k] = 0;
      left[k] = mask[k] ? rounds : 0;
      if (mask[k]) begin
        cv[k] = 1'b1;
        ca[k] = aq[k].pop_front();
      end
    end
    done = 1'b0;
    for (int cyc = 0; cyc < 800 && !done; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < NC; k++) begin
        if (cv[k]) begin
          if (cr[k]) begin
            if (hold[k] > 0) hold[k]--;
            else begin
              cv[k]   = 1'b0;
              left[k] = left[k] - 1;
              hold[k] = int'($urandom_range(0, 2));
            end
          end
        end else if (left[k] > 0 && !cr[k]) begin
          cv[k] = 1'b1;
          ca[k] = aq[k].pop_front();
        end
      end
      done = (left[0] == 0) && (left[1] == 0) && (left[2] == 0) && (cv == 3'b000) && (cr == 3'b000);
    end
    chk("batch_completes", 32'(done), 32'd1);
  endtask

  // Release every core once it has been answered.
  task automatic serve_rest();
    bit done;
    done = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < NC; k++) if (cv[k] && cr[k]) cv[k] = 1'b0;
      done = (cv == 3'b000) && (cr == 3'b000);
    end
    chk("serve_completes", 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cv    = 3'b000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sbq.delete();
    m_ptr = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    for (int i = 0; i < 256; i++) memtab[i] = 16'($urandom);
    memtab[8'h05] = 16'hA123;
    reset = 1'b1;
    cv    = 3'b000;
    for (int k = 0; k < NC; k++) ca[k] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_valid", 32'(mem_read_valid), 32'd0);
    chk("rst_mem_addr", 32'(mem_read_address), 32'd0);
    chk("rst_ready", 32'(cr), 32'd0);
    for (int k = 0; k < NC; k++) chk("rst_data", 32'(cd[k]), 32'd0);
    reset = 1'b0;

    // Single fetch with cycle-exact latency
    mem_delay = 2;
    plan(3'b001, 1, 1'b1, 8'h05, 8'h00, 8'h00);
    void'(aq[0].pop_front());
    @(negedge clk); cv[0] = 1'b1; ca[0] = 8'h05;           // cycle 0
    @(negedge clk);                                          // cycle 1
    chk("sf_mem_valid_c1", 32'(mem_read_valid), 32'd1);
    chk("sf_mem_addr_c1", 32'(mem_read_address), 32'h05);
    @(negedge clk);                                          // cycle 2
    chk("sf_mem_valid_c2", 32'(mem_read_valid), 32'd1);
    @(negedge clk);                                          // cycle 3
    chk("sf_mem_valid_c3", 32'(mem_read_valid), 32'd1);
    chk("sf_ready_c3", 32'(cr), 32'd0);
    @(negedge clk);                                          // cycle 4
    chk("sf_mem_valid_c4", 32'(mem_read_valid), 32'd0);
    chk("sf_ready_c4", 32'(cr), 32'b001);
    chk("sf_data_c4", 32'(cd[0]), 32'hA123);
    @(negedge clk);                                          // cycle 5
    chk("sf_ready_c5", 32'(cr), 32'b001);
    cv[0] = 1'b0;
    @(negedge clk);                                          // cycle 6
    chk("sf_ready_c6", 32'(cr), 32'd0);
    chk("sf_data_kept", 32'(cd[0]), 32'hA123);

    // Contention: all three cores, zero-wait memory
    do_reset();
    mem_delay = 0;
    grants.delete();
    run_batch(3'b111, 2);
    chk("rr_count", 32'(grants.size()), 32'd6);
    for (int i = 0; i < 6 && i < grants.size(); i++) chk("rr_order", 32'(grants[i]), 32'(i % 3));

    // Non-zero pointer: after core 1, cores 0 and 2 together -> 2 first
    mem_delay = 1;
    run_batch(3'b010, 1);
    grants.delete();
    run_batch(3'b101, 1);
    chk("ptr_first", 32'((grants.size() > 0) ? grants[0] : -1), 32'd2);

    // Early drop by core 1 while waiting; core 2 served next
    mem_delay = 3;
    grants.delete();
    plan(3'b110, 1, 1'b0, 8'h0, 8'h0, 8'h0);
    @(negedge clk);
    cv[1] = 1'b1; ca[1] = aq[1].pop_front();
    cv[2] = 1'b1; ca[2] = aq[2].pop_front();
    @(negedge clk);
    @(negedge clk);
    cv[1] = 1'b0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge clk);
      seen = cr[1];
    end
    chk("early_ready_seen", 32'(seen), 32'd1);
    @(negedge clk);
    chk("early_pulse_width", 32'(cr[1]), 32'd0);
    serve_rest();
    chk("early_next_core", 32'((grants.size() > 1) ? grants[1] : -1), 32'd2);

    // Reset in the middle of a transaction
    mem_delay = 10;
    @(negedge clk); cv[0] = 1'b1; ca[0] = 8'h33;
    @(negedge clk);
    @(negedge clk);
    chk("mid_mem_valid", 32'(mem_read_valid), 32'd1);
    reset = 1'b1; cv = 3'b000;
    @(negedge clk);
    chk("mid_rst_mem_valid", 32'(mem_read_valid), 32'd0);
    chk("mid_rst_mem_addr", 32'(mem_read_address), 32'd0);
    chk("mid_rst_ready", 32'(cr), 32'd0);
    for (int k = 0; k < NC; k++) chk("mid_rst_data", 32'(cd[k]), 32'd0);
    reset = 1'b0;
    sbq.delete();
    m_ptr = 0;
    @(negedge clk);
    pulse_req++;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      chk("late_ready_ignored", 32'(cr), 32'd0);
      chk("late_no_mem_valid", 32'(mem_read_valid), 32'd0);
    end
    mem_delay = 1;
    grants.delete();
    run_batch(3'b110, 1);
    chk("post_rst_lowest", 32'((grants.size() > 0) ? grants[0] : -1), 32'd1);

    // Address held while waiting despite consumer change
    mem_delay = 3;
    plan(3'b001, 1, 1'b1, 8'h10, 8'h00, 8'h00);
    void'(aq[0].pop_front());
    @(negedge clk); cv[0] = 1'b1; ca[0] = 8'h10;
    @(negedge clk);
    @(negedge clk); ca[0] = 8'h20;
    @(negedge clk);
    chk("addr_hold_c3", 32'(mem_read_address), 32'h10);
    @(negedge clk);
    chk("addr_hold_c4", 32'(mem_read_address), 32'h10);
    serve_rest();

    // Randomized batches with random memory latency
    mem_delay = -1;
    for (int it = 0; it < 25; it++) begin
      logic [2:0] m;
      m = 3'($urandom_range(1, 7));
      run_batch(m, int'($urandom_range(1, 3)));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
